// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port synchronous SRAM between the instruction-fetch port
//   (I) and the memory-stage port (D) of the 5-stage CPU. One access per cycle.
//   The SRAM has 1-cycle read latency. Read data goes back to the port that
//   issued the read.
//
//   Arbitration:
//     Default build: D wins a conflict. The exception is when I has already
//     been denied MAX_WAIT cycles in a row. In that case I is force-granted.
//     ARB_ROUND_ROBIN_EN defined: the conflict winner is the requester that
//     did not own the most recent grant.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_req/addr              I read request (addr held until inst_gnt)
//   inst_gnt                   I accepted this cycle (combinational)
//   inst_rvalid/rdata          I read response, cycle after grant
//   data_req/wen/addr/wdata    D request (wen==0 means read)
//   data_gnt                   D accepted this cycle (combinational)
//   data_rvalid/rdata          D read response, cycle after read grant
//   mem_en/wen/addr/wdata      SRAM command port
//   mem_rdata                  SRAM read data (cycle after read enable)
//   busy                       a read response is outstanding this cycle
module sram_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam logic       OWN_D       = 1'b0;
    localparam logic       OWN_I       = 1'b1;
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_resp_pending;
    logic       r_resp_owner;
`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_owner;
`endif

    logic w_i_gnt;
    logic w_d_gnt;
    logic w_read;

    // Grant decision. While reset is high, no request is granted.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!reset) begin
            if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                w_i_gnt = (r_last_owner == OWN_D);
`else
                w_i_gnt = (r_wait_cnt == LP_MAX_WAIT);
`endif
                w_d_gnt = !w_i_gnt;
            end else begin
                w_i_gnt = inst_req;
                w_d_gnt = data_req;
            end
        end
    end

    // Every I grant is a read. A D grant is a read only when no byte lane is written.
    assign w_read = w_i_gnt || (w_d_gnt && (data_wen == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt     <= 4'd0;
            r_resp_pending <= 1'b0;
            r_resp_owner   <= OWN_D;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner   <= OWN_D;
`endif
        end else begin
            // Count consecutive denied I cycles. Saturate at the force-grant threshold.
            if (inst_req && !w_i_gnt) begin
                if (r_wait_cnt != LP_MAX_WAIT)
                    r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end

            r_resp_pending <= w_read;
            if (w_read)
                r_resp_owner <= w_i_gnt ? OWN_I : OWN_D;
`ifdef ARB_ROUND_ROBIN_EN
            if (w_i_gnt || w_d_gnt)
                r_last_owner <= w_i_gnt ? OWN_I : OWN_D;
`endif
        end
    end

    assign inst_gnt  = w_i_gnt;
    assign data_gnt  = w_d_gnt;

    assign mem_en    = w_i_gnt || w_d_gnt;
    assign mem_wen   = w_d_gnt ? data_wen : '0;
    assign mem_addr  = w_d_gnt ? data_addr : inst_addr;
    assign mem_wdata = data_wdata;

    // A response registered just before reset is suppressed while reset is high.
    // The register is cleared at the same edge, so no response survives reset.
    assign busy        = r_resp_pending && !reset;
    assign inst_rvalid = busy && (r_resp_owner == OWN_I);
    assign data_rvalid = busy && (r_resp_owner == OWN_D);
    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] mem[bit [31:0]];

    localparam logic [31:0] IADDR = 32'hBFC00000;
    localparam logic [31:0] IDATA = 32'h3C1D0001;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with byte writes and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen != 4'b0) begin
                logic [31:0] w;
                w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                mem[mem_addr] = w;
            end else begin
                mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (inst_rvalid && data_rvalid)
            chk("both_rvalid", 32'(inst_rvalid & data_rvalid), 32'h0);
        if (inst_rvalid) begin
            if (exp_i.size() == 0) chk("unexpected_inst_rvalid", 32'h1, 32'h0);
            else chk("inst_rdata", inst_rdata, exp_i.pop_front());
        end
        if (data_rvalid) begin
            if (exp_d.size() == 0) chk("unexpected_data_rvalid", 32'h1, 32'h0);
            else chk("data_rdata", data_rdata, exp_d.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_ig;
        mem[32'h100] = 32'h11223344;
        mem[IADDR]   = IDATA;
        mem_rdata  = 32'h0;
        reset      = 1'b1;
        inst_req   = 1'b1;
        inst_addr  = IADDR;
        data_req   = 1'b1;
        data_wen   = 4'b0;
        data_addr  = 32'h100;
        data_wdata = 32'h0;

        // Reset with both requests high: nothing may be granted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
            chk("rst_data_gnt", 32'(data_gnt), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            step();
        end

        // Continuous conflict after release.
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_ig = (c % 2 == 0);
`else
            exp_ig = (c % 5 == 4);
`endif
            @(negedge clk);
            chk($sformatf("conf_inst_gnt_%0d", c), 32'(inst_gnt), 32'(exp_ig));
            chk($sformatf("conf_data_gnt_%0d", c), 32'(data_gnt), 32'(!exp_ig));
            chk($sformatf("conf_mem_addr_%0d", c), mem_addr, exp_ig ? IADDR : 32'h100);
            if (exp_ig) exp_i.push_back(IDATA);
            else        exp_d.push_back(32'h11223344);
            step();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'h0);
        chk("idle_busy_tail", 32'(busy), 32'h1);
        step();

        // I-only read.
        inst_req = 1'b1;
        @(negedge clk);
        chk("iread_gnt", 32'(inst_gnt), 32'h1);
        chk("iread_mem_en", 32'(mem_en), 32'h1);
        chk("iread_mem_addr", mem_addr, IADDR);
        chk("iread_mem_wen", 32'(mem_wen), 32'h0);
        exp_i.push_back(IDATA);
        step();
        inst_req = 1'b0;
        @(negedge clk);
        chk("iread_busy", 32'(busy), 32'h1);
        step();

        // Partial write, then read-back of the merged word.
        data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h100; data_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("wr_gnt", 32'(data_gnt), 32'h1);
        chk("wr_mem_wen", 32'(mem_wen), 32'h3);
        chk("wr_mem_wdata", mem_wdata, 32'hAABBCCDD);
        step();
        data_wen = 4'b0;
        @(negedge clk);
        chk("rd_gnt", 32'(data_gnt), 32'h1);
        chk("rd_mem_wen", 32'(mem_wen), 32'h0);
        chk("wr_no_busy", 32'(busy), 32'h0);
        exp_d.push_back(32'h1122CCDD);
        step();
        data_req = 1'b0;
        @(negedge clk);
        chk("rd_busy", 32'(busy), 32'h1);
        step();

        // Alternating single requests.
        for (int c = 0; c < 4; c++) begin
            inst_req = (c % 2 == 0);
            data_req = (c % 2 == 1);
            @(negedge clk);
            chk($sformatf("alt_inst_gnt_%0d", c), 32'(inst_gnt), 32'(c % 2 == 0));
            chk($sformatf("alt_data_gnt_%0d", c), 32'(data_gnt), 32'(c % 2 == 1));
            if (c % 2 == 0) exp_i.push_back(IDATA);
            else            exp_d.push_back(32'h1122CCDD);
            step();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        step();

        // A read is granted and reset follows at once: the response is dropped.
        inst_req = 1'b1;
        @(negedge clk);
        chk("rst5_gnt", 32'(inst_gnt), 32'h1);
        step();
        inst_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst5_busy", 32'(busy), 32'h0);
        chk("rst5_rvalid", 32'(inst_rvalid), 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_rvalid", 32'(inst_rvalid), 32'h0);
        step();
        step();

        chk("exp_i_drained", 32'(exp_i.size()), 32'h0);
        chk("exp_d_drained", 32'(exp_d.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
